// File: rtl/prf_scalable_pkg.sv
// Shared definitions for the scalable physical register file.
// Latency: n/a (types, defaults and helpers only).
// Backpressure: n/a.
//
// Holds default sizes, the CDB broadcast struct, the PRF entry struct and the
// rename->PRF / PRF->dispatch lane structs used by the surrounding pipeline.
package prf_scalable_pkg;

   localparam int PR_SIZE_DEF  = 48;
   localparam int PR_BITS_DEF  = $clog2(PR_SIZE_DEF);
   localparam int XLEN_DEF     = 64;
   localparam int THR_BITS_DEF = 1;

   // One completion broadcast.
   typedef struct packed {
      logic [PR_BITS_DEF-1:0] prn;
      logic                   valid;
      logic [XLEN_DEF-1:0]    fu_result;
   } cdb_t;

   // Architectural view of one physical register.
   typedef struct packed {
      logic                    busy;
      logic                    ready;
      logic [THR_BITS_DEF-1:0] thread_id;
      logic [XLEN_DEF-1:0]     value;
   } prf_entry_t;

   // Rename/RAT -> PRF, one lane.
   typedef struct packed {
      logic                    write;
      logic [THR_BITS_DEF-1:0] thread;
      logic [PR_BITS_DEF-1:0]  prn_opa;
      logic [PR_BITS_DEF-1:0]  prn_opb;
   } rat_prf_t;

   // PRF -> dispatch, one lane.
   typedef struct packed {
      logic [PR_BITS_DEF-1:0] alloc_prn;
      logic                   alloc_valid;
      logic                   opa_ready;
      logic                   opb_ready;
      logic [XLEN_DEF-1:0]    opa_value;
      logic [XLEN_DEF-1:0]    opb_value;
   } prf_dispatch_t;

   // Thread-id width; a single-thread build still carries one bit.
   function automatic int thr_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prf_scalable_if.sv
// Bundle of all non-clock/reset signals between rename/dispatch and the PRF.
// Latency: n/a (wires only).
// Backpressure: none; allocation offers carry their own valid bits.
//
// Modports: master = rename/RAT/CDB/retire side (drives requests),
//           slave  = PRF (drives alloc offers, operand reads, free_count).
interface prf_scalable_if #(
   parameter int PR_SIZE     = prf_scalable_pkg::PR_SIZE_DEF,
   parameter int PR_BITS     = $clog2(PR_SIZE),
   parameter int DISP_WIDTH  = 2,
   parameter int CDB_WIDTH   = 2,
   parameter int RET_WIDTH   = 4,
   parameter int NUM_THREADS = 2,
   parameter int XLEN        = prf_scalable_pkg::XLEN_DEF
);
   import prf_scalable_pkg::*;

   localparam int THR_BITS = thr_bits(NUM_THREADS);

   logic [NUM_THREADS-1:0]                mispredict;
   logic [NUM_THREADS-1:0][PR_SIZE-1:0]   rrat_owned;
   logic [RET_WIDTH-1:0]                  ret_free_valid;
   logic [RET_WIDTH-1:0][PR_BITS-1:0]     ret_free_prn;
   logic [DISP_WIDTH-1:0]                 disp_write;
   logic [DISP_WIDTH-1:0][THR_BITS-1:0]   disp_thread;
   logic [DISP_WIDTH-1:0][PR_BITS-1:0]    disp_prn_opa;
   logic [DISP_WIDTH-1:0][PR_BITS-1:0]    disp_prn_opb;
   logic [CDB_WIDTH-1:0]                  cdb_valid;
   logic [CDB_WIDTH-1:0][PR_BITS-1:0]     cdb_prn;
   logic [CDB_WIDTH-1:0][XLEN-1:0]        cdb_value;
   logic [DISP_WIDTH-1:0][PR_BITS-1:0]    alloc_prn;
   logic [DISP_WIDTH-1:0]                 alloc_valid;
   logic [DISP_WIDTH-1:0]                 opa_ready;
   logic [DISP_WIDTH-1:0]                 opb_ready;
   logic [DISP_WIDTH-1:0][XLEN-1:0]       opa_value;
   logic [DISP_WIDTH-1:0][XLEN-1:0]       opb_value;
   logic [PR_BITS:0]                      free_count;

   modport master (
      output mispredict, rrat_owned, ret_free_valid, ret_free_prn,
             disp_write, disp_thread, disp_prn_opa, disp_prn_opb,
             cdb_valid, cdb_prn, cdb_value,
      input  alloc_prn, alloc_valid, opa_ready, opb_ready,
             opa_value, opb_value, free_count
   );

   modport slave (
      input  mispredict, rrat_owned, ret_free_valid, ret_free_prn,
             disp_write, disp_thread, disp_prn_opa, disp_prn_opb,
             cdb_valid, cdb_prn, cdb_value,
      output alloc_prn, alloc_valid, opa_ready, opb_ready,
             opa_value, opb_value, free_count
   );

endinterface

// File: rtl/prf_scalable_free_alloc.sv
// Free-list picker: DISP_WIDTH lowest-index free entries plus free popcount.
// Latency: purely combinational.
// Backpressure: none; lanes beyond the free count get valid=0.
//
// Ports: busy/zero_mask in (PR_SIZE bits); free_idx/free_vld out per lane;
//        free_cnt out (PR_BITS+1 bits).
module prf_free_alloc #(
   parameter int PR_SIZE    = 48,
   parameter int PR_BITS    = $clog2(PR_SIZE),
   parameter int DISP_WIDTH = 2
) (
   input  logic [PR_SIZE-1:0]                 busy,
   input  logic [PR_SIZE-1:0]                 zero_mask,
   output logic [DISP_WIDTH-1:0][PR_BITS-1:0] free_idx,
   output logic [DISP_WIDTH-1:0]              free_vld,
   output logic [PR_BITS:0]                   free_cnt
);

   // Walk entries in index order; the running count says which lane the
   // next free entry belongs to, so lane i gets the i-th lowest free entry.
   always_comb begin
      free_idx = '0;
      free_vld = '0;
      free_cnt = '0;
      for (int e = 0; e < PR_SIZE; e++) begin
         if (!busy[e] && !zero_mask[e]) begin
            for (int l = 0; l < DISP_WIDTH; l++) begin
               if (free_cnt == (PR_BITS+1)'(l)) begin
                  free_idx[l] = PR_BITS'(e);
                  free_vld[l] = 1'b1;
               end
            end
            free_cnt = free_cnt + (PR_BITS+1)'(1);
         end
      end
   end

endmodule

// File: rtl/prf_scalable.sv
// Physical register file with free list, ready bits and per-thread ownership.
// Latency: operand reads combinational; claims/frees/CDB writes visible next cycle.
// Backpressure: none; a lane may only claim when its alloc_valid is set.
//
// Ports: clock, reset (sync, active-high); bus = prf_scalable_if.slave carrying
//        mispredict/rrat_owned, retire frees, dispatch lanes, CDB ports,
//        alloc offers, operand read results and free_count.
// Build option: PRF_BYPASS_EN forwards same-cycle CDB data to operand reads.
module prf_scalable
   import prf_scalable_pkg::*;
#(
   parameter int PR_SIZE     = PR_SIZE_DEF,
   parameter int PR_BITS     = $clog2(PR_SIZE),
   parameter int DISP_WIDTH  = 2,
   parameter int CDB_WIDTH   = 2,
   parameter int RET_WIDTH   = 4,
   parameter int NUM_THREADS = 2,
   parameter int XLEN        = XLEN_DEF
) (
   input logic           clock,
   input logic           reset,
   prf_scalable_if.slave bus
);

   localparam int THR_BITS = thr_bits(NUM_THREADS);
   localparam int ZERO_PRN = PR_SIZE - 1;
   localparam logic [PR_SIZE-1:0] ZERO_MASK = {1'b1, {(PR_SIZE-1){1'b0}}};

   logic [PR_SIZE-1:0]                busy_q,   busy_d;
   logic [PR_SIZE-1:0]                ready_q,  ready_d;
   logic [PR_SIZE-1:0][XLEN-1:0]      value_q,  value_d;
   logic [PR_SIZE-1:0][THR_BITS-1:0]  thread_q, thread_d;

   logic [DISP_WIDTH-1:0][PR_BITS-1:0] alloc_prn;
   logic [DISP_WIDTH-1:0]              alloc_valid;
   logic [PR_BITS:0]                   free_count;
   logic [DISP_WIDTH-1:0]              claim;
   logic [PR_SIZE-1:0]                 squash;
   logic [PR_SIZE-1:0]                 retire;

   logic [DISP_WIDTH-1:0]              opa_ready, opb_ready;
   logic [DISP_WIDTH-1:0][XLEN-1:0]    opa_value, opb_value;

   // Offers come from registered busy state, so an entry freed this cycle
   // only becomes visible to the picker next cycle.
   prf_free_alloc #(
      .PR_SIZE    (PR_SIZE),
      .PR_BITS    (PR_BITS),
      .DISP_WIDTH (DISP_WIDTH)
   ) u_free_alloc (
      .busy      (busy_q),
      .zero_mask (ZERO_MASK),
      .free_idx  (alloc_prn),
      .free_vld  (alloc_valid),
      .free_cnt  (free_count)
   );

   // A lane claims only a real offer, and never for a thread being squashed.
   always_comb begin
      claim = '0;
      for (int i = 0; i < DISP_WIDTH; i++) begin
         claim[i] = bus.disp_write[i] && alloc_valid[i] &&
                    !bus.mispredict[bus.disp_thread[i]];
      end
   end

   // Per-entry free sources. The zero register is never busy and never freed.
   always_comb begin
      squash = '0;
      retire = '0;
      for (int e = 0; e < PR_SIZE - 1; e++) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            if (bus.mispredict[t] && busy_q[e] &&
                thread_q[e] == THR_BITS'(t) && !bus.rrat_owned[t][e]) begin
               squash[e] = 1'b1;
            end
         end
         for (int r = 0; r < RET_WIDTH; r++) begin
            if (bus.ret_free_valid[r] && bus.ret_free_prn[r] == PR_BITS'(e)) begin
               retire[e] = 1'b1;
            end
         end
      end
   end

   // Next state. Priority per entry: squash > retire > CDB. Claims target
   // entries that are free at the start of the cycle, so they never overlap
   // a free or an accepted CDB write and can be applied last.
   always_comb begin
      busy_d   = busy_q;
      ready_d  = ready_q;
      value_d  = value_q;
      thread_d = thread_q;
      for (int e = 0; e < PR_SIZE - 1; e++) begin
         if (squash[e]) begin
            busy_d[e]  = 1'b0;
            ready_d[e] = 1'b1;
         end else if (retire[e]) begin
            busy_d[e] = 1'b0;
         end else if (busy_q[e]) begin
            // Scan high to low so the lowest matching port lands last.
            for (int p = CDB_WIDTH - 1; p >= 0; p--) begin
               if (bus.cdb_valid[p] && bus.cdb_prn[p] == PR_BITS'(e)) begin
                  ready_d[e] = 1'b1;
                  value_d[e] = bus.cdb_value[p];
               end
            end
         end
      end
      for (int i = 0; i < DISP_WIDTH; i++) begin
         if (claim[i]) begin
            busy_d[alloc_prn[i]]   = 1'b1;
            ready_d[alloc_prn[i]]  = 1'b0;
            thread_d[alloc_prn[i]] = bus.disp_thread[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q   <= '0;
         ready_q  <= '1;
         value_q  <= '0;
         thread_q <= '0;
      end else begin
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         value_q  <= value_d;
         thread_q <= thread_d;
      end
   end

   // Operand read. A non-ready entry returns its own PRN as a wakeup tag.
   function automatic void read_op(input  logic [PR_BITS-1:0] prn,
                                   output logic               rdy,
                                   output logic [XLEN-1:0]    val);
      rdy = 1'b0;
      val = XLEN'(prn);
      if (prn == PR_BITS'(ZERO_PRN)) begin
         rdy = 1'b1;
         val = '0;
      end else if (32'(prn) < PR_SIZE) begin
         if (ready_q[prn]) begin
            rdy = 1'b1;
            val = value_q[prn];
         end
`ifdef PRF_BYPASS_EN
         // Forward only what the entry would accept, lowest port winning.
         if (busy_q[prn]) begin
            for (int p = CDB_WIDTH - 1; p >= 0; p--) begin
               if (bus.cdb_valid[p] && bus.cdb_prn[p] == prn) begin
                  rdy = 1'b1;
                  val = bus.cdb_value[p];
               end
            end
         end
`endif
      end
   endfunction

   always_comb begin
      opa_ready = '0;
      opb_ready = '0;
      opa_value = '0;
      opb_value = '0;
      for (int i = 0; i < DISP_WIDTH; i++) begin
         read_op(bus.disp_prn_opa[i], opa_ready[i], opa_value[i]);
         read_op(bus.disp_prn_opb[i], opb_ready[i], opb_value[i]);
      end
   end

   assign bus.alloc_prn   = alloc_prn;
   assign bus.alloc_valid = alloc_valid;
   assign bus.free_count  = free_count;
   assign bus.opa_ready   = opa_ready;
   assign bus.opb_ready   = opb_ready;
   assign bus.opa_value   = opa_value;
   assign bus.opb_value   = opb_value;

endmodule

// File: tb/tb_prf_scalable.sv
// Directed bench for prf_scalable at default parameters.
module tb_prf_scalable;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_errors;

   prf_scalable_if bus ();

   prf_scalable dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.mispredict     = '0;
      bus.rrat_owned     = '0;
      bus.ret_free_valid = '0;
      bus.ret_free_prn   = '0;
      bus.disp_write     = '0;
      bus.disp_thread    = '0;
      bus.cdb_valid      = '0;
      bus.cdb_prn        = '0;
      bus.cdb_value      = '0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      clear_inputs();
      bus.disp_prn_opa = '0;
      bus.disp_prn_opb = '0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;

      // 1. Reset state
      bus.disp_prn_opa[0] = 6'd47;
      #1;
      chk("rst_alloc0", 64'(bus.alloc_prn[0]), 64'd0);
      chk("rst_alloc1", 64'(bus.alloc_prn[1]), 64'd1);
      chk("rst_avalid", 64'(bus.alloc_valid), 64'd3);
      chk("rst_fcount", 64'(bus.free_count), 64'd47);
      chk("rst_z_rdy", 64'(bus.opa_ready[0]), 64'd1);
      chk("rst_z_val", bus.opa_value[0], 64'd0);

      // 2. Claim both lanes: lane0 thread0 gets PRN0, lane1 thread1 gets PRN1
      bus.disp_write  = 2'b11;
      bus.disp_thread = 2'b10;
      step();
      clear_inputs();
      bus.disp_prn_opa[0] = 6'd0;
      bus.disp_prn_opb[0] = 6'd1;
      bus.disp_prn_opa[1] = 6'd47;
      #1;
      chk("clm_alloc0", 64'(bus.alloc_prn[0]), 64'd2);
      chk("clm_alloc1", 64'(bus.alloc_prn[1]), 64'd3);
      chk("clm_fcount", 64'(bus.free_count), 64'd45);
      chk("clm_p0_rdy", 64'(bus.opa_ready[0]), 64'd0);
      chk("clm_p0_tag", bus.opa_value[0], 64'd0);
      chk("clm_p1_rdy", 64'(bus.opb_ready[0]), 64'd0);
      chk("clm_p1_tag", bus.opb_value[0], 64'd1);
      chk("clm_z_rdy", 64'(bus.opa_ready[1]), 64'd1);

      // 3. CDB writes PRN0=55 (port0), PRN1=66 (port1)
      bus.cdb_valid    = 2'b11;
      bus.cdb_prn[0]   = 6'd0;
      bus.cdb_prn[1]   = 6'd1;
      bus.cdb_value[0] = 64'd55;
      bus.cdb_value[1] = 64'd66;
      #1;
`ifdef PRF_BYPASS_EN
      chk("cdb_now_rdya", 64'(bus.opa_ready[0]), 64'd1);
      chk("cdb_now_vala", bus.opa_value[0], 64'd55);
      chk("cdb_now_rdyb", 64'(bus.opb_ready[0]), 64'd1);
      chk("cdb_now_valb", bus.opb_value[0], 64'd66);
`else
      chk("cdb_now_rdya", 64'(bus.opa_ready[0]), 64'd0);
      chk("cdb_now_vala", bus.opa_value[0], 64'd0);
      chk("cdb_now_rdyb", 64'(bus.opb_ready[0]), 64'd0);
      chk("cdb_now_valb", bus.opb_value[0], 64'd1);
`endif
      step();
      clear_inputs();
      #1;
      chk("cdb_nxt_rdya", 64'(bus.opa_ready[0]), 64'd1);
      chk("cdb_nxt_vala", bus.opa_value[0], 64'd55);
      chk("cdb_nxt_rdyb", 64'(bus.opb_ready[0]), 64'd1);
      chk("cdb_nxt_valb", bus.opb_value[0], 64'd66);

      // 4. Mispredict thread1 frees PRN1; lane1 thread1 claim of PRN3 dropped
      bus.mispredict  = 2'b10;
      bus.disp_write  = 2'b10;
      bus.disp_thread = 2'b10;
      step();
      clear_inputs();
      #1;
      chk("mp_alloc0", 64'(bus.alloc_prn[0]), 64'd1);
      chk("mp_alloc1", 64'(bus.alloc_prn[1]), 64'd2);
      chk("mp_fcount", 64'(bus.free_count), 64'd46);
      chk("mp_p0_val", bus.opa_value[0], 64'd55);
      chk("mp_p1_kept", bus.opb_value[0], 64'd66);

      // 5. Retire {0, 47, 0}: PRN0 freed once, zero register ignored
      bus.ret_free_valid  = 4'b0111;
      bus.ret_free_prn[0] = 6'd0;
      bus.ret_free_prn[1] = 6'd47;
      bus.ret_free_prn[2] = 6'd0;
      step();
      clear_inputs();
      #1;
      chk("ret_fcount", 64'(bus.free_count), 64'd47);
      chk("ret_alloc0", 64'(bus.alloc_prn[0]), 64'd0);
      chk("ret_alloc1", 64'(bus.alloc_prn[1]), 64'd1);

      // Retire beats CDB on the same entry
      bus.disp_write = 2'b01;
      step();
      clear_inputs();
      #1;
      chk("pri_fc_claim", 64'(bus.free_count), 64'd46);
      bus.ret_free_valid  = 4'b0001;
      bus.ret_free_prn[0] = 6'd0;
      bus.cdb_valid       = 2'b01;
      bus.cdb_prn[0]      = 6'd0;
      bus.cdb_value[0]    = 64'd77;
      step();
      clear_inputs();
      #1;
      chk("pri_fcount", 64'(bus.free_count), 64'd47);
      chk("pri_p0_rdy", 64'(bus.opa_ready[0]), 64'd0);
      chk("pri_p0_val", bus.opa_value[0], 64'd0);

      // CDB to the zero register is ignored
      bus.cdb_valid    = 2'b01;
      bus.cdb_prn[0]   = 6'd47;
      bus.cdb_value[0] = 64'd99;
      step();
      clear_inputs();
      bus.disp_prn_opa[1] = 6'd47;
      #1;
      chk("zcdb_rdy", 64'(bus.opa_ready[1]), 64'd1);
      chk("zcdb_val", bus.opa_value[1], 64'd0);
      chk("zcdb_fc", 64'(bus.free_count), 64'd47);

      // 6. Drain the free list two at a time: 47 -> 1 in 23 cycles
      bus.disp_write  = 2'b11;
      bus.disp_thread = 2'b00;
      for (int k = 0; k < 23; k++) step();
      clear_inputs();
      #1;
      chk("drn_fcount", 64'(bus.free_count), 64'd1);
      chk("drn_avalid", 64'(bus.alloc_valid), 64'd1);
      chk("drn_alloc0", 64'(bus.alloc_prn[0]), 64'd46);
      bus.disp_write = 2'b10;
      step();
      clear_inputs();
      #1;
      chk("inv_fcount", 64'(bus.free_count), 64'd1);
      bus.disp_write = 2'b01;
      step();
      clear_inputs();
      #1;
      chk("emp_fcount", 64'(bus.free_count), 64'd0);
      chk("emp_avalid", 64'(bus.alloc_valid), 64'd0);

      // Thread0 squash with RRAT holding all but PRN5
      bus.mispredict    = 2'b01;
      bus.rrat_owned[0] = '1;
      bus.rrat_owned[0][5] = 1'b0;
      step();
      clear_inputs();
      bus.disp_prn_opa[0] = 6'd5;
      bus.disp_prn_opb[0] = 6'd6;
      #1;
      chk("sq_fcount", 64'(bus.free_count), 64'd1);
      chk("sq_alloc0", 64'(bus.alloc_prn[0]), 64'd5);
      chk("sq_avalid", 64'(bus.alloc_valid), 64'd1);
      chk("sq_p5_rdy", 64'(bus.opa_ready[0]), 64'd1);
      chk("sq_p6_rdy", 64'(bus.opb_ready[0]), 64'd0);
      chk("sq_p6_tag", bus.opb_value[0], 64'd6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/prf_scalable.md
# prf_scalable

Parametrised physical register file for the dual-thread out-of-order core, successor to the fixed two-lane PRF. It sits between rename/RAT and dispatch. It holds PR_SIZE values with ready bits and per-entry thread ownership, and offers DISP_WIDTH destination registers per cycle from an internal free list. It reads two source operands per lane, absorbs CDB_WIDTH completion broadcasts, and reclaims registers both on retirement and on per-thread mispredict recovery.

## Interface
Parameters:
- PR_SIZE, 48, physical registers; entry PR_SIZE-1 is the hardwired zero register
- PR_BITS, $clog2(PR_SIZE), PRN width
- DISP_WIDTH, 2, rename/dispatch lanes
- CDB_WIDTH, 2, broadcast ports
- RET_WIDTH, 4, retirement free ports
- NUM_THREADS, 2, hardware threads
- XLEN, 64, value width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- mispredict  in  NUM_THREADS  per-thread squash
- rrat_owned  in  NUM_THREADS×PR_SIZE  entries held by each thread's retirement RAT
- ret_free_valid / ret_free_prn  in  RET_WIDTH / RET_WIDTH×PR_BITS  retired old destinations
- disp_write  in  DISP_WIDTH  lane claims alloc_prn[i]
- disp_thread  in  DISP_WIDTH×1  owning thread
- disp_prn_opa, disp_prn_opb  in  DISP_WIDTH×PR_BITS  source PRNs
- cdb_valid / cdb_prn / cdb_value  in  CDB_WIDTH / ×PR_BITS / ×XLEN
- alloc_prn  out  DISP_WIDTH×PR_BITS  offered destination per lane
- alloc_valid  out  DISP_WIDTH  offer is real
- opa_ready, opb_ready  out  DISP_WIDTH
- opa_value, opb_value  out  DISP_WIDTH×XLEN
- free_count  out  PR_BITS+1

## Operation
- Per-entry state: busy (allocated), ready, value, thread.
- Allocation:
  - Lane i is offered the i-th lowest-index free entry, taken from free state at the start of the cycle.
  - alloc_valid[i] = free_count > i.
  - The offer is positional: an idle lower lane does not shift offers to higher lanes.
- Claim: disp_write[i] && alloc_valid[i] sets busy=1, ready=0, thread=disp_thread[i] at posedge. disp_write on an invalid offer is ignored.
- Read:
  - Ready entry returns ready=1 and its value.
  - Non-ready entry returns ready=0, value = PRN zero-extended (tag passthrough).
  - PRN PR_SIZE-1 always returns ready=1, value 0.
- CDB: for a valid port to a busy entry, set ready=1 and value. Writes to free entries or to the zero register are ignored. On duplicate PRNs, the lowest port index wins.
- Retire free: clears busy for the listed PRN. Already-free entries or PR_SIZE-1 are ignored; duplicates are harmless.
- Mispredict[t]: every busy entry with thread==t and rrat_owned[t] bit clear becomes free (busy=0, ready=1, value kept).
  - Lanes with disp_thread==t have their claims suppressed that cycle.
  - The other thread is unaffected.
- Same-cycle priority per entry: reset > mispredict free > retire free > CDB write. Claims never collide with frees because offers come from the free set.
- free_count = number of non-busy entries, excluding PR_SIZE-1.

## Timing
- Reset state: all entries busy=0, ready=1, value=0. free_count=PR_SIZE-1.
- Reset outputs: alloc_prn[i]=i, alloc_valid all 1.
- Read outputs are combinational over registered state.
- Offers, claims, frees and CDB writes take effect one cycle after posedge.
- A register freed in cycle n is offered no earlier than cycle n+1.
- Reset asserted mid-operation discards all pending claims and frees that cycle.

## Configuration
- PRF_BYPASS_EN defined: a same-cycle CDB match forwards to operand reads (ready=1, cdb_value), with the lowest port index winning.
- PRF_BYPASS_EN undefined: reads see CDB data only from the next cycle.

## Structure
- Shared definitions header holds:
  - PR_SIZE, PR_BITS, XLEN defaults
  - CDB struct (PRN, valid, FU_result)
  - PRF entry struct (busy, ready, thread_id, value)
  - RAT_PRF and PRF_DISPATCH lane structs
- Sub-module prf_free_alloc: takes the busy vector plus the zero-register mask and returns DISP_WIDTH lowest free indices with valid bits and the popcount.

## Test plan
Default parameters throughout.
1. Reset → alloc_prn {0,1}, alloc_valid {1,1}, free_count 47; reading PRN 47 gives ready=1, value 0.
2. disp_write {1,1}, threads {0,1} → next cycle alloc_prn {2,3}, free_count 45. Reading PRN 0 gives ready=0, value 0; reading PRN 1 gives ready=0, value 1.
3. CDB {PRN0=55, PRN1=66} while reading PRN 0 and 1:
   - Bypass on: ready=1, values 55/66 in the same cycle.
   - Bypass off: ready=0 in that cycle; 55/66 the next cycle.
4. After scenario 2, mispredict[1] with rrat_owned[1]=0 → next cycle alloc_prn {1,2}, free_count 46, PRN 0 still busy. A lane-1 claim by thread 1 in the mispredict cycle is dropped.
5. ret_free {PRN0, PRN47, PRN0} → PRN 0 freed once, PRN 47 ignored, free_count +1.
6. Allocate until free_count=1 → alloc_valid {1,0}. disp_write on lane 1 changes no state; free_count reaches 0 after the lane-0 claim.
